// File: rtl/cpp_internal_double_to_bool_convert_mc.sv
// rtl/cpp_internal_double_to_bool_convert_mc.sv - multi-channel double-to-bool converter with hysteresis and debounce
//
// Purpose: converts NCH IEEE-754 double inputs into logic levels. Each level
//   rises when the input exceeds HI_TH and falls when it is at or below LO_TH.
//   A switch needs DEBOUNCE consecutive qualifying evaluations. Evaluations are
//   requested by toggling update_in and are acknowledged two clocks later on
//   update_out.
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in         in   64*NCH   channel k double bits at [64*k+63:64*k]
//   update_in  in   1        toggle strobe, each change requests one evaluation
//   out        out  NCH      per-channel logic level
//   update_out out  1        update_in delayed by 2 clk
//   nan_err    out  NCH      sticky NaN flag (only with CPP_D2B_NAN_FLAG_EN)
// Optional feature macro: CPP_D2B_NAN_FLAG_EN

module cpp_internal_double_to_bool_convert_mc #(
  parameter int          NCH      = 1,
  parameter logic [63:0] HI_TH    = 64'h3F847AE147AE147B,
  parameter logic [63:0] LO_TH    = 64'h3F847AE147AE147B,
  parameter int          DEBOUNCE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [64*NCH-1:0] in,
  input  logic              update_in,
  output logic [NCH-1:0]    out,
  output logic              update_out
`ifdef CPP_D2B_NAN_FLAG_EN
  ,
  output logic [NCH-1:0]    nan_err
`endif
);

  // Map a double onto an unsigned key whose order matches numeric order.
  // -0.0 is folded onto +0.0 so both compare as equal.
  function automatic logic [63:0] f_key(input logic [63:0] x);
    logic [63:0] v;
    v = (x == 64'h8000_0000_0000_0000) ? 64'd0 : x;
    return v[63] ? ~v : {1'b1, v[62:0]};
  endfunction

  function automatic logic f_is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  localparam logic [63:0] KEY_HI = f_key(HI_TH);
  localparam logic [63:0] KEY_LO = f_key(LO_TH);
  localparam int          CW     = $clog2(DEBOUNCE + 1);
  localparam logic [CW:0] DB     = (CW + 1)'(DEBOUNCE);

  typedef enum logic {ST_LOW = 1'b0, ST_HIGH = 1'b1} state_t;

  logic           r_upd_q;
  logic           r_upd_q2;
  logic           w_eval;
  logic           r_eval_s1;
  logic [NCH-1:0] r_gt_hi;
  logic [NCH-1:0] r_le_lo;
  logic [NCH-1:0] r_nan;
  state_t         r_state     [NCH];
  state_t         w_state_nxt [NCH];
  logic [CW-1:0]  r_cnt       [NCH];
  logic [CW-1:0]  w_cnt_nxt   [NCH];
  logic [CW:0]    w_inc       [NCH];
  logic [NCH-1:0] w_qual;

  // Any edge of the toggle strobe relative to its registered copy is a request.
  assign w_eval = update_in ^ r_upd_q;

  // Stage 0 (strobe capture) and stage 1 (per-channel compare results).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_q   <= 1'b0;
      r_upd_q2  <= 1'b0;
      r_eval_s1 <= 1'b0;
      r_gt_hi   <= '0;
      r_le_lo   <= '0;
      r_nan     <= '0;
    end else begin
      r_upd_q   <= update_in;
      r_upd_q2  <= r_upd_q;
      r_eval_s1 <= w_eval;
      for (int k = 0; k < NCH; k++) begin
        r_gt_hi[k] <= (f_key(in[64*k +: 64]) >  KEY_HI);
        r_le_lo[k] <= (f_key(in[64*k +: 64]) <= KEY_LO);
        r_nan[k]   <= f_is_nan(in[64*k +: 64]);
      end
    end
  end

  // Stage 2: per-channel hysteresis FSM state and debounce counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        r_state[k] <= ST_LOW;
        r_cnt[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_cnt[k]   <= w_cnt_nxt[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_state_nxt[k] = r_state[k];
      w_cnt_nxt[k]   = r_cnt[k];
      w_inc[k]       = {1'b0, r_cnt[k]} + {{CW{1'b0}}, 1'b1};
      // The qualifying direction depends on the current level.
      w_qual[k]      = (r_state[k] == ST_LOW) ? r_gt_hi[k] : r_le_lo[k];
      // NaN leaves both level and counter untouched.
      if (r_eval_s1 && !r_nan[k]) begin
        if (!w_qual[k]) begin
          w_cnt_nxt[k] = '0;
        end else if (w_inc[k] == DB) begin
          // Switching clears the counter, so it never passes DEBOUNCE.
          w_state_nxt[k] = (r_state[k] == ST_LOW) ? ST_HIGH : ST_LOW;
          w_cnt_nxt[k]   = '0;
        end else begin
          w_cnt_nxt[k] = w_inc[k][CW-1:0];
        end
      end
    end
  end

  always_comb begin
    out = '0;
    for (int k = 0; k < NCH; k++) begin
      out[k] = (r_state[k] == ST_HIGH);
    end
  end

  assign update_out = r_upd_q2;

`ifdef CPP_D2B_NAN_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_err <= '0;
    end else if (r_eval_s1) begin
      nan_err <= nan_err | r_nan;
    end
  end
`endif

endmodule
